// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the two-port RAM arbiter: both req/ack ports plus the
// clear command and busy status. The arbiter uses the slave view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              clear;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clear,
    input  ack0, ack1, rdata0, rdata1, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clear,
    output ack0, ack1, rdata0, rdata1, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port access controller for a single-port word RAM with a
// combinational read port; zero-fills the RAM after reset and on command.
module ram_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    S_INIT,
    S_CLEAR,
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clear_pend_q, clear_pend_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1, winner;

  // A port still showing its ack this cycle is not eligible, so a request held
  // through its ack is not served a second time.
  assign elig0  = bus.req0 & ~ack_q[0];
  assign elig1  = bus.req1 & ~ack_q[1];
  assign winner = (elig0 & elig1) ? ~last_q : elig1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_pend_d = clear_pend_q;
    last_d       = last_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = '0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      S_INIT: begin
        cnt_d = '0;
        if (CLEAR_EN) begin
          state_d      = S_CLEAR;
          clear_pend_d = 1'b0;
        end else begin
          state_d      = S_IDLE;
          clear_pend_d = clear_pend_q | bus.clear;
        end
      end

      S_CLEAR: begin
        cnt_d        = cnt_q + ADDR_W'(1);
        clear_pend_d = clear_pend_q | bus.clear;
        if (cnt_q == '1) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (clear_pend_q | bus.clear) begin
          state_d      = S_CLEAR;
          clear_pend_d = 1'b0;
          cnt_d        = '0;
        end else if (elig0 | elig1) begin
          state_d = S_ACCESS;
          id_d    = winner;
          last_d  = winner;
          we_d    = winner ? bus.we1    : bus.we0;
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
        end
      end

      S_ACCESS: begin
        state_d       = S_IDLE;
        ack_d[id_q]   = 1'b1;
        clear_pend_d  = clear_pend_q | bus.clear;
        if (!we_q) begin
          if (id_q) rdata1_d = ram_out;
          else      rdata0_d = ram_out;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      clear_pend_q <= 1'b0;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_pend_q <= clear_pend_d;
      last_q       <= last_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // RAM pins decode from the registered state, so ram_load drops as soon as
  // reset asserts.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        ram_address = cnt_q;
        ram_load    = 1'b1;
      end
      S_ACCESS: begin
        ram_address = addr_q;
        ram_in      = wdata_q;
        ram_load    = we_q;
      end
      default: ;
    endcase
  end

  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = (state_q == S_INIT) || (state_q == S_CLEAR);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model of the arbiter and RAM checked
// every cycle, plus directed scenarios with hand-derived expectations.
module tb_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  logic              ram_load;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_EN(1'b1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out)
  );

  always #5 clock = ~clock;

  // Single-port RAM: write on load at posedge, combinational read.
  logic [DATA_W-1:0] ram [DEPTH];
  assign ram_out = ram[ram_address];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'hFFFF;
    forever begin
      @(posedge clock);
      if (ram_load) ram[ram_address] <= ram_in;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rdata [2];
  bit                m_init, m_sweep, m_acc, m_acc_port, m_acc_we, m_last, m_pend;
  int                m_sweep_addr, m_acc_addr;
  logic [DATA_W-1:0] m_acc_wdata;
  bit [1:0]          m_ack;

  task automatic model_reset();
    m_init     = 1'b1;
    m_sweep    = 1'b0;
    m_acc      = 1'b0;
    m_ack      = 2'b00;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_last     = 1'b1;
    m_pend     = 1'b0;
  endtask

  task automatic model_step();
    bit [1:0] nack;
    bit       e0, e1, w;
    nack = 2'b00;
    if (m_init) begin
      m_init       = 1'b0;
      m_sweep      = 1'b1;
      m_sweep_addr = 0;
      m_pend       = 1'b0;
    end else if (m_sweep) begin
      m_mem[m_sweep_addr] = '0;
      m_pend = m_pend | bus.clear;
      if (m_sweep_addr == DEPTH - 1) m_sweep = 1'b0;
      else m_sweep_addr++;
    end else if (m_acc) begin
      if (m_acc_we) m_mem[m_acc_addr] = m_acc_wdata;
      else m_rdata[m_acc_port] = m_mem[m_acc_addr];
      nack[m_acc_port] = 1'b1;
      m_pend = m_pend | bus.clear;
      m_acc  = 1'b0;
    end else begin
      if (m_pend || bus.clear) begin
        m_sweep      = 1'b1;
        m_sweep_addr = 0;
        m_pend       = 1'b0;
      end else begin
        e0 = bus.req0 && !m_ack[0];
        e1 = bus.req1 && !m_ack[1];
        if (e0 || e1) begin
          w           = (e0 && e1) ? !m_last : e1;
          m_acc       = 1'b1;
          m_acc_port  = w;
          m_acc_we    = w ? bus.we1 : bus.we0;
          m_acc_addr  = int'(w ? bus.addr1 : bus.addr0);
          m_acc_wdata = w ? bus.wdata1 : bus.wdata0;
          m_last      = w;
        end
      end
    end
    m_ack = nack;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hFFFF;
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    bit exp_load;
    forever begin
      @(negedge clock);
      exp_load = m_sweep || (m_acc && m_acc_we);
      check("ack0",   bus.ack0,   m_ack[0]);
      check("ack1",   bus.ack1,   m_ack[1]);
      check("rdata0", bus.rdata0, m_rdata[0]);
      check("rdata1", bus.rdata1, m_rdata[1]);
      check("busy",   bus.busy,   m_init || m_sweep);
      check("ram_load", ram_load, exp_load);
      if (exp_load) begin
        check("ram_address", ram_address, m_sweep ? m_sweep_addr : m_acc_addr);
        check("ram_in",      ram_in,      m_sweep ? 0 : m_acc_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rd);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    @(negedge clock);
    #1 drive(port, 1'b1, we, addr, wdata);
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      seen = port ? bus.ack1 : bus.ack0;
    end
    check("ack_seen", seen, 1);
    rd = port ? bus.rdata1 : bus.rdata0;
    #1 drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_not_busy(output int busy_cycles, output int load_cycles);
    busy_cycles = 0;
    load_cycles = 0;
    @(negedge clock);
    while (bus.busy && busy_cycles < 5000) begin
      busy_cycles++;
      if (ram_load) load_cycles++;
      @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DATA_W-1:0] rd;
    int bc, lc, n;
    bit e0, e1;

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    bus.clear = 1'b0;

    // Reset release into INIT then a full zero-fill sweep.
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check("init_busy", bus.busy, 1);
    check("init_load", ram_load, 0);
    check("init_addr", ram_address, 0);
    wait_not_busy(bc, lc);
    check("sweep_busy_cycles", bc, 4097);
    check("sweep_load_cycles", lc, 4096);
    access(1'b0, 1'b0, 12'd0,    '0, rd); check("read_0_after_sweep",    rd, 16'h0000);
    access(1'b1, 1'b0, 12'd2047, '0, rd); check("read_2047_after_sweep", rd, 16'h0000);
    access(1'b0, 1'b0, 12'd4095, '0, rd); check("read_4095_after_sweep", rd, 16'h0000);

    // Write latency: load in T+1, ack in T+2; then read-back from the other port.
    @(negedge clock);
    #1 drive(1'b0, 1'b1, 1'b1, 12'h123, 16'hBEEF);
    @(posedge clock); #1;
    check("wr_load_t1", ram_load, 1);
    check("wr_addr_t1", ram_address, 12'h123);
    check("wr_data_t1", ram_in, 16'hBEEF);
    check("wr_noack_t1", bus.ack0, 0);
    @(posedge clock); #1;
    check("wr_ack_t2", bus.ack0, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    access(1'b1, 1'b0, 12'h123, '0, rd); check("rd1_after_wr0", rd, 16'hBEEF);

    // Both ports held: grants alternate starting with port 0.
    @(negedge clock);
    #1 drive(1'b0, 1'b1, 1'b0, 12'h123, '0);
    drive(1'b1, 1'b1, 1'b0, 12'h123, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      e0 = (k % 2 == 0) && ((k / 2) % 2 == 1);
      e1 = (k % 2 == 0) && ((k / 2) % 2 == 0);
      check("rr_ack0", bus.ack0, e0);
      check("rr_ack1", bus.ack1, e1);
    end
    #1 drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    check("rr_rdata0", bus.rdata0, 16'hBEEF);
    check("rr_rdata1", bus.rdata1, 16'hBEEF);

    // Request held past its ack: no duplicate in the ack cycle, re-served after.
    @(negedge clock);
    #1 drive(1'b0, 1'b1, 1'b0, 12'h7FF, '0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("hold_ack0", bus.ack0, (k == 2) || (k == 5));
      if (k == 5) #1 drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    check("hold_rdata0", bus.rdata0, 16'h0000);

    // clear during a port-1 write: ack still arrives, then a full sweep.
    @(negedge clock);
    #1 drive(1'b1, 1'b1, 1'b1, 12'h200, 16'h1234);
    @(negedge clock);
    #1 bus.clear = 1'b1;
    @(negedge clock);
    check("clr_ack1", bus.ack1, 1);
    check("clr_not_busy_yet", bus.busy, 0);
    #1 bus.clear = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    n  = 0;
    bc = 0;
    e0 = 1'b0;
    while (!e0 && n < 5000) begin
      @(negedge clock);
      n++;
      if (bus.busy) bc++;
      e0 = bus.ack0;
      if (n == 100) #1 drive(1'b0, 1'b1, 1'b0, 12'h200, '0);
    end
    check("clr_ack0_delay", n, 4099);
    check("clr_sweep_cycles", bc, 4096);
    check("clr_rdata0", bus.rdata0, 16'h0000);
    #1 drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Reset asserted in the ACCESS cycle of a write.
    repeat (2) @(negedge clock);
    #1 drive(1'b0, 1'b1, 1'b1, 12'h300, 16'h5555);
    @(posedge clock); #2;
    check("rst_pre_load", ram_load, 1);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_load", ram_load, 0);
    check("rst_ack0", bus.ack0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_addr", ram_address, 0);
    repeat (2) @(posedge clock);
    check("rst_no_commit", ram[12'h300], 16'h0000);
    #1 reset_n = 1'b1;
    check("rst_init_busy", bus.busy, 1);
    wait_not_busy(bc, lc);
    check("rst_sweep_cycles", bc, 4097);

    // Top address behaves like any other; same-address write then read.
    access(1'b1, 1'b0, 12'h300, '0, rd);          check("post_rst_read", rd, 16'h0000);
    access(1'b0, 1'b1, 12'hFFF, 16'hA5A5, rd);
    access(1'b1, 1'b0, 12'hFFF, '0, rd);          check("top_addr_read", rd, 16'hA5A5);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
